// File: rtl/compare_arbiter.sv
// ---------------------------------------------------------------------------
// compare_arbiter
//
// Round-robin arbiter and sequencer sharing one N-bit equality comparator
// among R requesters. A request is granted in IDLE. Its operands are latched
// into the comparator and compared in CMP. The registered result, tagged
// with the requester ID, is presented in RESP until the consumer accepts it.
//
// Ports:
//   clk        single clock, all state on rising edge
//   rst        synchronous reset, active-high
//   req_valid  [R]     requester i has an operand pair pending
//   req_ready  [R]     requester i's pair accepted this cycle (one-hot or 0)
//   req_a      [R*N]   operand A, requester i at [i*N +: N]
//   req_b      [R*N]   operand B, requester i at [i*N +: N]
//   rsp_valid          result available
//   rsp_ready          consumer accepts result
//   rsp_id     [IDW]   requester index the result belongs to
//   rsp_equal          1 when A == B for that request
//   busy               1 whenever the sequencer is not idle
// ---------------------------------------------------------------------------

// Shared comparator. Its flag uses mismatch sense: high when the operands differ.
module comparison_flags #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         equal_to_flag
);
  assign equal_to_flag = (a != b);
endmodule

module compare_arbiter #(
  parameter int N   = 8,
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_equal,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [N-1:0]   op_a, op_b;
  logic           eq_q;
  logic           mismatch;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  comparison_flags #(.N(N)) u_cmp (
    .a             (op_a),
    .b             (op_b),
    .equal_to_flag (mismatch)
  );

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  // modulo R. The modulo keeps the index below R even when R is not a
  // power of two.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < R; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr) + k) % R]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(rr_ptr) + k) % R);
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        // Reset held high must not accept anything, even with requests pending.
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          state_d              = CMP;
        end
      end
      CMP:  state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      id_q    <= '0;
      eq_q    <= 1'b0;
      // NOTE: the operand registers are reset too, so the comparator never
      // sees X after reset and rsp_equal starts from a known value.
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_found) begin
        op_a   <= req_a[int'(grant_idx)*N +: N];
        op_b   <= req_b[int'(grant_idx)*N +: N];
        id_q   <= grant_idx;
        rr_ptr <= (grant_idx == IDW'(R - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state_q == CMP) begin
        eq_q <= ~mismatch;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_equal = eq_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_compare_arbiter.sv
// ---------------------------------------------------------------------------
// tb_compare_arbiter
//
// Directed bench for compare_arbiter. It uses two instances: d0 with the
// default parameters (N=8, R=4), and d1 with N=1, R=3. Inputs change 1 ns
// after the rising edge. Outputs are checked 1 ns after that.
// ---------------------------------------------------------------------------
module tb_compare_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  v0, rr0;
  logic [31:0] a0, b0;
  logic        rv0, rrdy0, req0, busy0;
  logic [1:0]  rid0;

  logic [2:0]  v1, rr1;
  logic [2:0]  a1, b1;
  logic        rv1, rrdy1, req1, busy1;
  logic [1:0]  rid1;

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  compare_arbiter d0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (v0),
    .req_ready (rr0),
    .req_a     (a0),
    .req_b     (b0),
    .rsp_valid (rv0),
    .rsp_ready (rrdy0),
    .rsp_id    (rid0),
    .rsp_equal (req0),
    .busy      (busy0)
  );

  compare_arbiter #(.N(1), .R(3)) d1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (v1),
    .req_ready (rr1),
    .req_a     (a1),
    .req_b     (b1),
    .rsp_valid (rv1),
    .rsp_ready (rrdy1),
    .rsp_id    (rid1),
    .rsp_equal (req1),
    .busy      (busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with rsp_ready held high. It starts in an IDLE
  // cycle and returns in the next IDLE cycle. The request stays asserted.
  task automatic grant_cycle(input bit sel, input logic [3:0] valid, input int exp_g,
                             input logic exp_eq, input string tag);
    if (sel) v1 = valid[2:0];
    else     v0 = valid;
    #1;
    check({tag, " grant"}, sel ? 32'(rr1) : 32'(rr0), 32'(1) << exp_g);
    tick();
    check({tag, " cmp busy"},  sel ? 32'(busy1) : 32'(busy0), 32'd1);
    check({tag, " cmp ready"}, sel ? 32'(rr1) : 32'(rr0), 32'd0);
    check({tag, " cmp rsp_valid"}, sel ? 32'(rv1) : 32'(rv0), 32'd0);
    tick();
    check({tag, " rsp_valid"}, sel ? 32'(rv1) : 32'(rv0), 32'd1);
    check({tag, " rsp_id"},    sel ? 32'(rid1) : 32'(rid0), 32'(exp_g));
    check({tag, " rsp_equal"}, sel ? 32'(req1) : 32'(req0), 32'(exp_eq));
    tick();
    check({tag, " idle rsp_valid"}, sel ? 32'(rv1) : 32'(rv0), 32'd0);
  endtask

  initial begin
    logic [3:0] rr_valid [10];
    int         rr_exp   [10];

    rst = 1'b1;
    v0 = 4'hF; a0 = '0; b0 = '0; rrdy0 = 1'b1;
    v1 = 3'b111; a1 = '0; b1 = '0; rrdy1 = 1'b1;

    // 1. Reset held for three cycles with every request pending.
    repeat (3) tick();
    check("rst req_ready", 32'(rr0), 32'd0);
    check("rst rsp_valid", 32'(rv0), 32'd0);
    check("rst rsp_id",    32'(rid0), 32'd0);
    check("rst rsp_equal", 32'(req0), 32'd0);
    check("rst busy",      32'(busy0), 32'd0);
    check("rst d1 ready",  32'(rr1), 32'd0);
    check("rst d1 busy",   32'(busy1), 32'd0);
    v1 = '0;
    rst = 1'b0;
    grant_cycle(0, 4'hF, 0, 1'b1, "t1 first");
    v0 = '0;

    // 2. Single requester 2: equal, then LSB, bit-0 and bit-7 differences.
    a0 = {8'h00, 8'hA5, 16'h0}; b0 = {8'h00, 8'hA5, 16'h0};
    grant_cycle(0, 4'b0100, 2, 1'b1, "t2 eq");
    b0 = {8'h00, 8'hA4, 16'h0};
    grant_cycle(0, 4'b0100, 2, 1'b0, "t2 ne");
    a0 = {8'h00, 8'h3C, 16'h0}; b0 = {8'h00, 8'h3D, 16'h0};
    grant_cycle(0, 4'b0100, 2, 1'b0, "t2 bit0");
    a0 = {8'h00, 8'h5A, 16'h0}; b0 = {8'h00, 8'hDA, 16'h0};
    grant_cycle(0, 4'b0100, 2, 1'b0, "t2 bit7");
    v0 = '0;

    // 3. Round-robin. A one-cycle reset returns rr_ptr to 0. Requesters 1
    //    and 3 carry equal operands; requesters 0 and 2 carry unequal ones.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a0 = {8'h11, 8'h22, 8'h33, 8'h44};
    b0 = {8'h11, 8'h23, 8'h33, 8'h45};
    rr_valid = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1101};
    rr_exp   = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
    for (int i = 0; i < 10; i++) begin
      grant_cycle(0, rr_valid[i], rr_exp[i], (rr_exp[i] % 2) == 1, $sformatf("t3 rr%0d", i));
    end
    v0 = '0;

    // 4. Backpressure. rr_ptr is 3, so a lone request 0 wins. The
    //    response then stalls for 10 cycles while every requester waits.
    rrdy0 = 1'b0;
    v0 = 4'b0001;
    #1;
    check("t4 grant", 32'(rr0), 32'b0001);
    tick();
    v0 = 4'hF;
    #1;
    check("t4 cmp ready", 32'(rr0), 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t4 stall%0d valid", i), 32'(rv0), 32'd1);
      check($sformatf("t4 stall%0d id", i),    32'(rid0), 32'd0);
      check($sformatf("t4 stall%0d eq", i),    32'(req0), 32'd0);
      check($sformatf("t4 stall%0d ready", i), 32'(rr0), 32'd0);
      tick();
    end
    rrdy0 = 1'b1;
    #1;
    check("t4 accept valid", 32'(rv0), 32'd1);
    tick();
    check("t4 next grant", 32'(rr0), 32'b0010);
    tick();
    v0 = '0;
    tick();
    check("t4 next id", 32'(rid0), 32'd1);
    check("t4 next eq", 32'(req0), 32'd1);
    tick();

    // 5a. Reset asserted during CMP aborts the request for requester 2.
    v0 = 4'b0100;
    #1;
    check("t5 grant2", 32'(rr0), 32'b0100);
    tick();
    v0 = '0;
    rst = 1'b1;
    tick();
    check("t5 cmp-abort valid", 32'(rv0), 32'd0);
    check("t5 cmp-abort busy",  32'(busy0), 32'd0);
    rst = 1'b0;
    tick();
    check("t5 cmp-abort no rsp a", 32'(rv0), 32'd0);
    tick();
    check("t5 cmp-abort no rsp b", 32'(rv0), 32'd0);

    // 5b. Reset asserted during RESP aborts the request for requester 1.
    v0 = 4'b0010;
    #1;
    check("t5 grant1", 32'(rr0), 32'b0010);
    tick();
    v0 = '0;
    tick();
    check("t5 resp valid", 32'(rv0), 32'd1);
    rst = 1'b1;
    tick();
    check("t5 resp-abort valid", 32'(rv0), 32'd0);
    check("t5 resp-abort busy",  32'(busy0), 32'd0);
    rst = 1'b0;
    tick();
    check("t5 resp-abort no rsp", 32'(rv0), 32'd0);
    grant_cycle(0, 4'hF, 0, 1'b0, "t5 after reset");
    v0 = '0;

    // 6. N=1, R=3. Operands: req0 1/1, req1 1/0, req2 1/1.
    a1 = 3'b111; b1 = 3'b101;
    grant_cycle(1, 4'b0111, 0, 1'b1, "t6 g0");
    grant_cycle(1, 4'b0111, 1, 1'b0, "t6 g1");
    grant_cycle(1, 4'b0111, 2, 1'b1, "t6 g2");
    grant_cycle(1, 4'b0111, 0, 1'b1, "t6 wrap");
    v1 = '0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
